lane_game_sequencer: RTL

- Game-level controller for the three-lane player selector. The selector holds the one-hot `aim` lane position and moves it left or right on `ctl` commands.
- This block:
  - converts button presses into single-cycle `ctl` commands;
  - runs the game FSM (idle/play/hit/over);
  - generates and scrolls obstacles down three lanes;
  - detects collisions against `aim`;
  - keeps score and lives for the display path.

---
 rtl/lane_game_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lane_game_sequencer.sv
// Three-lane dodge game controller: button edges -> ctl pulses, game FSM, obstacle scroll, collisions, score/lives.
// Latency: all outputs registered, ctl one cycle after a button rise; no backpressure, runs every clk.
module lane_game_sequencer #(
    parameter int unsigned TICK_DIV  = 25000000,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned LIVES     = 3,
    parameter int unsigned HIT_TICKS = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            btn_l,
    input  logic            btn_r,
    input  logic [7:0]      aim,
    output logic [1:0]      ctl,
    output logic [ROWS-1:0] lane0,
    output logic [ROWS-1:0] lane1,
    output logic [ROWS-1:0] lane2,
    output logic [1:0]      state,
    output logic [15:0]     score,
    output logic [1:0]      lives,
    output logic            tick
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned HIT_W = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(HIT_TICKS - 1);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ctl_q, ctl_d;
    logic [ROWS-1:0] lane0_q, lane0_d, lane1_q, lane1_d, lane2_q, lane2_d;
    logic [15:0]     score_q, score_d;
    logic [1:0]      lives_q, lives_d;
    logic            tick_q, tick_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic            start_prev_q, btn_l_prev_q, btn_r_prev_q;

    logic       start_rise, l_rise, r_rise;
    logic       collide, any_bottom, running;
    logic [7:0] lfsr_next;

    assign start_rise = start & ~start_prev_q;
    assign l_rise     = btn_l & ~btn_l_prev_q;
    assign r_rise     = btn_r & ~btn_r_prev_q;

    // Only exact one-hot lane codes can collide; anything else is treated as off-grid.
    assign collide = ((aim == 8'h80) && lane0_q[ROWS-1]) ||
                     ((aim == 8'h02) && lane1_q[ROWS-1]) ||
                     ((aim == 8'h10) && lane2_q[ROWS-1]);
    assign any_bottom = lane0_q[ROWS-1] | lane1_q[ROWS-1] | lane2_q[ROWS-1];
    assign lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d   = state_q;
        ctl_d     = 2'b00;
        lane0_d   = lane0_q;
        lane1_d   = lane1_q;
        lane2_d   = lane2_q;
        score_d   = score_q;
        lives_d   = lives_q;
        lfsr_d    = lfsr_q;
        hit_cnt_d = hit_cnt_q;

        case (state_q)
            S_IDLE: begin
                lfsr_d = lfsr_next;
                if (start_rise) begin
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    lane0_d = '0;
                    lane1_d = '0;
                    lane2_d = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (collide) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d = S_OVER;
                    end else begin
                        state_d   = S_HIT;
                        hit_cnt_d = '0;
                        lane0_d   = '0;
                        lane1_d   = '0;
                        lane2_d   = '0;
                    end
                end else if (tick_q) begin
                    if (any_bottom && (score_q != 16'hFFFF)) begin
                        score_d = score_q + 16'd1;
                    end
                    // Spawn lane comes from the pre-step LFSR value; code 3 leaves the row empty.
                    lane0_d = {lane0_q[ROWS-2:0], (lfsr_q[1:0] == 2'd0)};
                    lane1_d = {lane1_q[ROWS-2:0], (lfsr_q[1:0] == 2'd1)};
                    lane2_d = {lane2_q[ROWS-2:0], (lfsr_q[1:0] == 2'd2)};
                    lfsr_d  = lfsr_next;
                end
            end
            S_HIT: begin
                if (tick_q) begin
                    if (hit_cnt_q == HIT_LAST) begin
                        state_d   = S_PLAY;
                        hit_cnt_d = '0;
                    end else begin
                        hit_cnt_d = hit_cnt_q + HIT_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_d = S_IDLE;
                    lane0_d = '0;
                    lane1_d = '0;
                    lane2_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Moves are only issued while play continues across this edge.
        if ((state_q == S_PLAY) && (state_d == S_PLAY)) begin
            if (l_rise && !r_rise) begin
                ctl_d = 2'b01;
            end else if (r_rise && !l_rise) begin
                ctl_d = 2'b10;
            end
        end
    end

    // Divider restarts on every state entry so each PLAY/HIT stint starts with a full period.
    always_comb begin
        running = (state_d == S_PLAY) || (state_d == S_HIT);
        if (!running || (state_d != state_q)) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        tick_d = running && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ctl_q        <= 2'b00;
            lane0_q      <= '0;
            lane1_q      <= '0;
            lane2_q      <= '0;
            score_q      <= '0;
            lives_q      <= LIVES_INIT;
            tick_q       <= 1'b0;
            div_q        <= '0;
            hit_cnt_q    <= '0;
            lfsr_q       <= LFSR_SEED;
            start_prev_q <= 1'b0;
            btn_l_prev_q <= 1'b0;
            btn_r_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctl_q        <= ctl_d;
            lane0_q      <= lane0_d;
            lane1_q      <= lane1_d;
            lane2_q      <= lane2_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            tick_q       <= tick_d;
            div_q        <= div_d;
            hit_cnt_q    <= hit_cnt_d;
            lfsr_q       <= lfsr_d;
            start_prev_q <= start;
            btn_l_prev_q <= btn_l;
            btn_r_prev_q <= btn_r;
        end
    end

    assign ctl   = ctl_q;
    assign lane0 = lane0_q;
    assign lane1 = lane1_q;
    assign lane2 = lane2_q;
    assign state = state_q;
    assign score = score_q;
    assign lives = lives_q;
    assign tick  = tick_q;

endmodule
